// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO plus MFHI/MFLO/MTHI/MTLO decode.
// The divide datapath and div_by_zero are built only when MIPS_MULDIV_DIV_EN is defined.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             md_sel,
    output logic [WIDTH-1:0] rd_data
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0]   acc, mq, m, acc_step, mq_step, mag_a, mag_b;
    logic [CW-1:0]      cnt;
    logic               neg_lo, go, is_mul, is_div, dz, start_op, sa, sb, sgn;
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] prod_fix, res;

    assign go       = start && alu_op == 3'b010 && state == IDLE;
    assign is_mul   = funct == F_MULT || funct == F_MULTU;
    assign sgn      = !funct[0];
    assign sa       = sgn && src_a[WIDTH-1];
    assign sb       = sgn && src_b[WIDTH-1];
    assign mag_a    = sa ? -src_a : src_a;
    assign mag_b    = sb ? -src_b : src_b;
    assign start_op = go && (is_mul || is_div);
    assign busy     = state != IDLE;
    assign md_sel   = alu_op == 3'b010 && (funct == F_MFHI || funct == F_MFLO);
    assign rd_data  = funct == F_MFHI ? hi : lo;
    // acc:mq holds partial product high half and the not-yet-consumed multiplier bits
    assign msum     = {1'b0, acc} + (mq[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    assign prod_fix = neg_lo ? -{acc, mq} : {acc, mq};

`ifdef MIPS_MULDIV_DIV_EN
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_DIVU = 6'b011011;
    logic           div_r, dz_r, neg_hi;
    logic [WIDTH:0] shl, diff;
    assign is_div = funct == F_DIV || funct == F_DIVU;
    assign dz     = is_div && src_b == '0;
    // restoring step: acc is the partial remainder, mq shifts dividend out and quotient in
    assign shl    = {acc, mq[WIDTH-1]};
    assign diff   = shl - {1'b0, m};
    assign {acc_step, mq_step} = div_r
        ? {diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0], mq[WIDTH-2:0], !diff[WIDTH]}
        : {msum, mq[WIDTH-1:1]};
    assign res = div_r ? {neg_hi ? -acc : acc, neg_lo ? -mq : mq} : prod_fix;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_r       <= 1'b0;
            dz_r        <= 1'b0;
            neg_hi      <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            if (start_op) begin
                div_r  <= is_div;
                dz_r   <= dz;
                neg_hi <= !dz && (is_div ? sa : sa ^ sb);
            end
            div_by_zero <= state == FIX && dz_r;
        end
    end
`else
    assign is_div              = 1'b0;
    assign dz                  = 1'b0;
    assign {acc_step, mq_step} = {msum, mq[WIDTH-1:1]};
    assign res                 = prod_fix;
    assign div_by_zero         = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (start_op ? (dz ? FIX : RUN) : IDLE)
                 : state == RUN  ? (cnt == '0 ? FIX : RUN)
                 : IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {acc, mq, m, hi, lo} <= '0;
            cnt    <= '0;
            neg_lo <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= state == FIX;
            if (start_op) begin
                acc    <= dz ? src_a : '0;
                mq     <= dz ? '1 : is_div ? mag_a : mag_b;
                m      <= is_div ? mag_b : mag_a;
                cnt    <= CW'(WIDTH - 1);
                neg_lo <= !dz && (sa ^ sb);
            end else if (state == RUN) begin
                acc <= acc_step;
                mq  <= mq_step;
                cnt <= cnt - 1'b1;
            end
            if (state == FIX) {hi, lo} <= res;
            else if (go && funct == F_MTHI) hi <= src_a;
            else if (go && funct == F_MTLO) lo <= src_a;
        end
    end
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: directed vectors, corner sequences and randomized ops vs. an arithmetic model.
module tb_mips_muldiv_unit;
    localparam int W = 32;
    localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;
    localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;

    logic clk = 0, reset_n = 0, start = 0;
    logic [2:0] alu_op = 0;
    logic [5:0] funct = 0;
    logic [W-1:0] src_a = 0, src_b = 0;
    logic busy, done, div_by_zero, md_sel;
    logic [W-1:0] hi, lo, rd_data;

    int total = 0, bad = 0;

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .alu_op(alu_op), .funct(funct),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo), .md_sel(md_sel), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]   f;
        logic [W-1:0] a, b, ehi, elo;
        logic         edz;
        int           ecyc;
        string        nm;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // present an R-type instruction for one cycle; returns just after the accept edge (cycle 1)
    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1; alu_op = 3'b010; funct = f; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input logic ez,
                          input int ec, input string nm);
        int n, busy_err;
        issue(f, a, b);
        n = 1; busy_err = 0;
        while (done !== 1'b1 && n <= 60) begin
            if (busy !== 1'b1) busy_err++;
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " done_cycle"}, 64'(n), 64'(ec));
        chk({nm, " busy_during"}, 64'(busy_err), 64'd0);
        chk({nm, " busy_at_done"}, 64'(busy), 64'd0);
        chk({nm, " hi"}, 64'(hi), 64'(eh));
        chk({nm, " lo"}, 64'(lo), 64'(el));
        chk({nm, " dz"}, 64'(div_by_zero), 64'(ez));
    endtask

    function automatic void model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] h, output logic [W-1:0] l,
                                  output logic z, output int cyc);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        z = 0; cyc = W + 2; p = 0;
        if (f == MULTU) p = {32'b0, a} * {32'b0, b};
        else if (f == MULT) p = 64'(sa * sb);
        else if (b == 0) begin
            p = {a, 32'hFFFF_FFFF}; z = 1; cyc = 2;
        end else if (f == DIVU) p = {a % b, a / b};
        else begin
            q = sa / sb; r = sa % sb;
            p = {r[31:0], q[31:0]};
        end
        {h, l} = p;
    endfunction

    initial begin
        logic [5:0] fr;
        logic [W-1:0] ra, rb, mh, ml, h0, l0;
        logic mz;
        int mc, dcount;

        vt.push_back('{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 34, "multu_max"});
        vt.push_back('{MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 34, "mult_neg3x7"});
        vt.push_back('{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 34, "mult_minxmin"});
        vt.push_back('{MULTU, 32'd0,         32'd12345,     32'h0,         32'h0,         0, 34, "multu_zero"});
        vt.push_back('{MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 0, 34, "mult_maxxm1"});
`ifdef MIPS_MULDIV_DIV_EN
        vt.push_back('{DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 34, "div_m7_2"});
        vt.push_back('{DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1, 2,  "divu_by0"});
        vt.push_back('{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 0, 34, "div_min_m1"});
        vt.push_back('{DIVU,  32'hFFFF_FFFF, 32'd16,        32'hF,         32'h0FFF_FFFF, 0, 34, "divu_max_16"});
        vt.push_back('{DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0, 34, "div_7_m2"});
        vt.push_back('{DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1, 2,  "div_by0"});
`endif

        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1;
        #1;
        chk("reset hi", 64'(hi), 0);
        chk("reset lo", 64'(lo), 0);
        chk("reset busy", 64'(busy), 0);
        chk("reset done", 64'(done), 0);
        chk("reset dz", 64'(div_by_zero), 0);

        foreach (vt[i]) run_op(vt[i].f, vt[i].a, vt[i].b, vt[i].ehi, vt[i].elo, vt[i].edz, vt[i].ecyc, vt[i].nm);

        // MFHI / MFLO after MULT -3 x 7
        run_op(MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 34, "mult_for_mf");
        @(negedge clk); alu_op = 3'b010; funct = MFHI; #1;
        chk("mfhi md_sel", 64'(md_sel), 1);
        chk("mfhi rd_data", 64'(rd_data), 64'hFFFF_FFFF);
        funct = MFLO; #1;
        chk("mflo md_sel", 64'(md_sel), 1);
        chk("mflo rd_data", 64'(rd_data), 64'hFFFF_FFEB);
        alu_op = 3'b000; funct = MFHI; #1;
        chk("mfhi non_rtype md_sel", 64'(md_sel), 0);

        // MTHI / MTLO: single-edge writes, no busy/done
        issue(MTHI, 32'hABCD, 32'd0);
        chk("mthi hi", 64'(hi), 64'hABCD);
        chk("mthi busy", 64'(busy), 0);
        issue(MTLO, 32'h1234, 32'd0);
        chk("mtlo lo", 64'(lo), 64'h1234);
        chk("mtlo hi_kept", 64'(hi), 64'hABCD);
        @(posedge clk); #1;
        chk("mtlo no_done", 64'(done), 0);

        // start while busy is ignored; LO holds until the first result lands
        issue(MULT, 32'd2, 32'd3);
        @(negedge clk);
        start = 1; alu_op = 3'b010; funct = MTLO; src_a = 32'hDEAD;
        repeat (2) @(negedge clk);
        funct = MULT; src_a = 32'd100; src_b = 32'd100;
        repeat (3) @(negedge clk);
        start = 0;
        chk("busy_ignore lo_held", 64'(lo), 64'h1234);
        chk("busy_ignore busy", 64'(busy), 1);
        mc = 0;
        while (done !== 1'b1 && mc < 60) begin @(posedge clk); #1; mc++; end
        chk("busy_ignore done_seen", 64'(done), 1);
        chk("busy_ignore hi", 64'(hi), 0);
        chk("busy_ignore lo", 64'(lo), 6);

        // non R-type alu_op is ignored
        @(negedge clk); start = 1; alu_op = 3'b000; funct = MULT; src_a = 9; src_b = 9;
        @(posedge clk); #1; start = 0;
        chk("non_rtype busy", 64'(busy), 0);
        chk("non_rtype lo", 64'(lo), 6);

        // asynchronous reset in cycle 10 of a MULTU
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("midreset busy", 64'(busy), 0);
        chk("midreset hi", 64'(hi), 0);
        chk("midreset lo", 64'(lo), 0);
        @(negedge clk) reset_n = 1;
        dcount = 0;
        repeat (40) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) dcount++; end
        chk("midreset no_done", 64'(dcount), 0);

`ifndef MIPS_MULDIV_DIV_EN
        issue(MTHI, 32'h55, 32'd0);
        issue(MTLO, 32'h66, 32'd0);
        issue(DIV, 32'd8, 32'd2);
        dcount = 0;
        repeat (5) begin if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) dcount++; @(posedge clk); #1; end
        chk("nodiv quiet", 64'(dcount), 0);
        chk("nodiv hi", 64'(hi), 64'h55);
        chk("nodiv lo", 64'(lo), 64'h66);
        issue(DIVU, 32'd5, 32'd0);
        #1;
        chk("nodiv divu0 busy", 64'(busy), 0);
        chk("nodiv divu0 dz", 64'(div_by_zero), 0);
`endif

        // randomized back-to-back ops against the arithmetic model
        for (int k = 0; k < 40; k++) begin
`ifdef MIPS_MULDIV_DIV_EN
            case ($urandom_range(0, 3))
                0: fr = MULT; 1: fr = MULTU; 2: fr = DIV; default: fr = DIVU;
            endcase
`else
            fr = $urandom_range(0, 1) ? MULT : MULTU;
`endif
            case ($urandom_range(0, 4))
                0: ra = 32'h8000_0000; 1: ra = 32'hFFFF_FFFF;
                2: ra = 32'($urandom_range(0, 40)) - 32'd20; default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'd0; 1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 9)); default: rb = $urandom;
            endcase
            model(fr, ra, rb, mh, ml, mz, mc);
            run_op(fr, ra, rb, mh, ml, mz, mc, $sformatf("rand%0d", k));
        end

        h0 = hi; l0 = lo;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Parametrised multiply/divide unit with HI/LO registers for the MIPS datapath, extending R-type ALU decoding with MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. It sits beside the main ALU in the execute stage and decodes `funct` when `alu_op` is 3'b010 (R-type). It runs iterative one-bit-per-cycle multiply and restoring divide, and asserts `busy` so the hazard unit stalls the pipeline until the result is in HI/LO.

## Interface

Parameters:
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits; must be at least 4.

Ports:
- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  a valid instruction is present in execute this cycle.
- `alu_op`  input  3  main-decoder ALUOp; only 3'b010 is acted on.
- `funct`  input  6  R-type funct field.
- `src_a`  input  WIDTH  rs operand; dividend or multiplicand.
- `src_b`  input  WIDTH  rt operand; divisor or multiplier.
- `busy`  output  1  an operation is in progress; the hazard unit stalls on it.
- `done`  output  1  one-cycle pulse; HI and LO were updated at the preceding edge.
- `div_by_zero`  output  1  pulses together with `done` when a divide had `src_b` equal to 0.
- `hi`  output  WIDTH  HI register.
- `lo`  output  WIDTH  LO register.
- `md_sel`  output  1  combinational; 1 when `alu_op`=010 and `funct` is MFHI (010000) or MFLO (010010); selects `rd_data` into the writeback mux.
- `rd_data`  output  WIDTH  combinational; equals `hi` for MFHI, `lo` otherwise.

## Operation

- An instruction is accepted at an edge where `start`=1, `alu_op`=010, `busy`=0 and `funct` is a recognised code.
  - Any other combination is ignored and causes no state change.
  - `start` while `busy`=1 is ignored; the stalled pipeline re-presents the instruction.
- MTHI (010001) and MTLO (010011):
  - HI or LO is loaded with `src_a` at the accept edge.
  - No `busy`, no `done`.
- MFHI and MFLO are purely combinational: `md_sel` and `rd_data` change, no state change.
- FSM has three states: IDLE, RUN, FIX.
  - IDLE, on accepted MULT, MULTU, DIV or DIVU: latch operand magnitudes, the signed/unsigned flag and the result sign; go to RUN with counter = `WIDTH`-1.
  - RUN: one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle. When the counter reaches 0, go to FIX.
  - FIX: negate the result if required, write HI and LO, go to IDLE. `done` pulses in the following cycle.
- Multiply: HI:LO is the 2·`WIDTH`-bit product.
  - MULT is two's-complement; MULTU is unsigned.
- Divide: LO is the quotient, HI is the remainder.
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
  - Most-negative ÷ −1 gives LO = 0x8000…0 and HI = 0.
- Divide by zero: IDLE goes directly to FIX.
  - HI = `src_a`, LO = all ones.
  - `div_by_zero` pulses with `done`.

## Timing

- Accept edge = E0.
- Normal multiply or divide:
  - `busy`=1 in cycles 1 through `WIDTH`+1.
  - HI and LO are written at edge E0+`WIDTH`+1.
  - `done` is high in cycle `WIDTH`+2, and `busy` is 0 in that same cycle.
- Divide by zero: `busy`=1 in cycle 1 only; `done` and `div_by_zero` are high in cycle 2.
- A new operation may be accepted in the same cycle that `done` is high.
- Reset values (asynchronous on `reset_n` low, including mid-operation):
  - state = IDLE.
  - `hi`, `lo` = 0.
  - `busy`, `done`, `div_by_zero` = 0.
  - No partial result survives.

## Configuration

- `MIPS_MULDIV_DIV_EN` defined:
  - DIV and DIVU are recognised.
  - The divide datapath and `div_by_zero` are built.
- Not defined:
  - DIV (011010) and DIVU (011011) are unrecognised and ignored.
  - `div_by_zero` is tied to 0.
  - Only the multiply datapath is built.

## Test plan

Scenarios use `WIDTH`=32; cycle numbers count from the accept edge E0.

- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `done` in cycle 34; `busy` high in cycles 1–33.
- MULT −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; then MFHI gives `md_sel`=1 and `rd_data`=0xFFFFFFFF.
- DIV −7 ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 5 ÷ 0 → HI=5, LO=0xFFFFFFFF, `div_by_zero` and `done` in cycle 2.
- MTLO 0x1234, then `start` with MULT while `busy`=1 → the second request is ignored; LO holds 0x1234 until the first result is written.
- `reset_n` pulled low in cycle 10 of a MULTU → `busy`=0 and HI=LO=0 immediately; no `done` follows.
- Build without `MIPS_MULDIV_DIV_EN`: DIV 8 ÷ 2 with `start` → `busy` stays 0, HI and LO are unchanged, `div_by_zero`=0.
